// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the shared register-file write port, with a
// pending-write scoreboard. Optional same-cycle bypass: define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter  int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [5*N_REQ-1:0]   req_addr,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic                 rf_wr_ena,
  output logic [4:0]           rf_wr_addr,
  output logic [31:0]          rf_wr_data,
  output logic [PTR_W-1:0]     grant_id,
  input  logic                 sb_set,
  input  logic [4:0]           sb_set_addr,
  input  logic [4:0]           sb_query_addr0,
  input  logic [4:0]           sb_query_addr1,
  output logic                 sb_busy0,
  output logic                 sb_busy1
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                 byp_hit0,
  output logic                 byp_hit1,
  output logic [31:0]          byp_data0,
  output logic [31:0]          byp_data1
`endif
);

  logic [4:0]       addr_arr [N_REQ];
  logic [31:0]      data_arr [N_REQ];

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             grant_vld;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   rr_sum;
  logic [PTR_W-1:0] rr_cand;

  logic             wr_ena_q, wr_ena_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [PTR_W-1:0] grant_id_q, grant_id_d;

  logic [31:0]      busy_q, busy_d;
  logic [31:0]      set_mask, clr_mask;
  logic             busy_raw0, busy_raw1;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[5*g +: 5];
    assign data_arr[g] = req_data[32*g +: 32];
  end

  // Scan from the pointer, wrapping at N_REQ; the first valid candidate wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (rr_sum >= (PTR_W+1)'(N_REQ)) rr_sum = rr_sum - (PTR_W+1)'(N_REQ);
      rr_cand = rr_sum[PTR_W-1:0];
      if (!grant_vld && req_valid[rr_cand]) begin
        grant_vld = 1'b1;
        grant_idx = rr_cand;
      end
    end
    req_ready = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    ptr_d      = ptr_q;
    wr_ena_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    if (grant_vld) begin
      ptr_d      = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
      wr_ena_d   = (addr_arr[grant_idx] != 5'd0);
      wr_addr_d  = addr_arr[grant_idx];
      wr_data_d  = data_arr[grant_idx];
      grant_id_d = grant_idx;
    end
  end

  // Set is applied after clear so a same-edge set on the committing register wins.
  always_comb begin
    set_mask = sb_set ? (32'd1 << sb_set_addr) : 32'd0;
    clr_mask = wr_ena_q ? (32'd1 << wr_addr_q) : 32'd0;
    busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  // NOTE: the busy bits are ordinary flops, not a RAM, so they take the async reset
  // like every other piece of state here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      wr_ena_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      busy_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      ptr_q      <= ptr_d;
      wr_ena_q   <= wr_ena_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wr_ena  = wr_ena_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign grant_id   = grant_id_q;

  assign busy_raw0 = busy_q[sb_query_addr0];
  assign busy_raw1 = busy_q[sb_query_addr1];

`ifdef REGFILE_WB_BYPASS_EN
  // A register being written this cycle is readable from the write port directly.
  assign byp_hit0  = wr_ena_q && (wr_addr_q == sb_query_addr0) && (sb_query_addr0 != 5'd0);
  assign byp_hit1  = wr_ena_q && (wr_addr_q == sb_query_addr1) && (sb_query_addr1 != 5'd0);
  assign byp_data0 = wr_data_q;
  assign byp_data1 = wr_data_q;
  assign sb_busy0  = busy_raw0 && !byp_hit0;
  assign sb_busy1  = busy_raw1 && !byp_hit1;
`else
  assign sb_busy0  = busy_raw0;
  assign sb_busy1  = busy_raw1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter (N_REQ=2): directed scenarios with literal checks plus
// a per-cycle comparison against a behavioural model. Honours REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;
  localparam int N_REQ = 2;

  logic              clk;
  logic              rst;
  logic [N_REQ-1:0]  req_valid;
  logic [N_REQ-1:0]  req_ready;
  logic [5*N_REQ-1:0]  req_addr;
  logic [32*N_REQ-1:0] req_data;
  logic              rf_wr_ena;
  logic [4:0]        rf_wr_addr;
  logic [31:0]       rf_wr_data;
  logic [0:0]        grant_id;
  logic              sb_set;
  logic [4:0]        sb_set_addr;
  logic [4:0]        q0, q1;
  logic              sb_busy0, sb_busy1;
`ifdef REGFILE_WB_BYPASS_EN
  logic              byp_hit0, byp_hit1;
  logic [31:0]       byp_data0, byp_data1;
`endif

  regfile_wb_arbiter #(.N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_wr_ena(rf_wr_ena), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .grant_id(grant_id),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .sb_query_addr0(q0), .sb_query_addr1(q1),
    .sb_busy0(sb_busy0), .sb_busy1(sb_busy1)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .byp_hit0(byp_hit0), .byp_hit1(byp_hit1),
    .byp_data0(byp_data0), .byp_data1(byp_data1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file driven by the DUT's write port.
  logic [31:0] rf_mem [32];
  initial for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
  always @(posedge clk) if (rf_wr_ena) rf_mem[rf_wr_addr] <= rf_wr_data;

  // ---------------- behavioural model ----------------
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_ena;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_gid;
  int          exp_k;

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int ptr);
    for (int j = 0; j < N_REQ; j++)
      if (v[(ptr + j) % N_REQ]) return (ptr + j) % N_REQ;
    return -1;
  endfunction

  always_comb exp_k = rr_pick(req_valid, m_ptr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr <= 0; m_busy <= '0; m_ena <= 1'b0; m_addr <= '0; m_data <= '0; m_gid <= 0;
    end else begin
      m_busy <= ((m_busy & ~(m_ena ? (32'd1 << m_addr) : 32'd0))
                 | (sb_set ? (32'd1 << sb_set_addr) : 32'd0)) & 32'hFFFF_FFFE;
      if (exp_k >= 0) begin
        m_ptr  <= (exp_k + 1) % N_REQ;
        m_addr <= req_addr[5*exp_k +: 5];
        m_data <= req_data[32*exp_k +: 32];
        m_gid  <= exp_k;
        m_ena  <= (req_addr[5*exp_k +: 5] != 5'd0);
      end else begin
        m_ena  <= 1'b0;
      end
    end
  end

  function automatic logic model_hit(input logic [4:0] q);
`ifdef REGFILE_WB_BYPASS_EN
    return m_ena && (m_addr == q) && (q != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("m_ready", 32'(req_ready), (exp_k >= 0) ? (32'd1 << exp_k) : 32'd0);
      check("m_ena", 32'(rf_wr_ena), 32'(m_ena));
      if (m_ena) begin
        check("m_addr", 32'(rf_wr_addr), 32'(m_addr));
        check("m_data", rf_wr_data, m_data);
        check("m_gid", 32'(grant_id), 32'(m_gid));
      end
      check("m_busy0", 32'(sb_busy0), 32'(m_busy[q0] && !model_hit(q0)));
      check("m_busy1", 32'(sb_busy1), 32'(m_busy[q1] && !model_hit(q1)));
`ifdef REGFILE_WB_BYPASS_EN
      check("m_hit0", 32'(byp_hit0), 32'(model_hit(q0)));
      check("m_hit1", 32'(byp_hit1), 32'(model_hit(q1)));
      if (model_hit(q1)) check("m_bdata1", byp_data1, m_data);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [1:0] rr_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [4:0] rr_addr  [4] = '{5'd1, 5'd2, 5'd1, 5'd2};

  initial begin
    rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    sb_set = 1'b0; sb_set_addr = '0; q0 = '0; q1 = '0;
    #1;
    check("rst_ena", 32'(rf_wr_ena), 32'd0);
    check("rst_addr", 32'(rf_wr_addr), 32'd0);
    check("rst_data", rf_wr_data, 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst = 1'b1;

    // Single writer
    step();
    req_valid = 2'b01; req_addr[4:0] = 5'd3; req_data[31:0] = 32'hDEAD_BEEF;
    #1 check("sw_ready", 32'(req_ready), 32'h1);
    step(); req_valid = '0;
    #1;
    check("sw_ena", 32'(rf_wr_ena), 32'd1);
    check("sw_addr", 32'(rf_wr_addr), 32'd3);
    check("sw_gid", 32'(grant_id), 32'd0);
    step();
    check("sw_rf", rf_mem[3], 32'hDEAD_BEEF);

    // x0 write from requester 1
    req_valid = 2'b10; req_addr[9:5] = 5'd0; req_data[63:32] = 32'hFFFF_FFFF; q0 = 5'd0;
    #1;
    check("x0_ready", 32'(req_ready), 32'h2);
    check("x0_busy", 32'(sb_busy0), 32'd0);
    step(); req_valid = '0;
    #1 check("x0_ena", 32'(rf_wr_ena), 32'd0);
    step();
    check("x0_rf", rf_mem[0], 32'd0);

    // Scoreboard lifecycle on x7
    sb_set = 1'b1; sb_set_addr = 5'd7; q0 = 5'd7;
    step(); sb_set = 1'b0;
    #1 check("sb_set", 32'(sb_busy0), 32'd1);
    req_valid = 2'b01; req_addr[4:0] = 5'd7; req_data[31:0] = 32'h77;
    step(); req_valid = '0;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("sb_wr_busy_byp", 32'(sb_busy0), 32'd0);
    check("sb_wr_hit", 32'(byp_hit0), 32'd1);
    check("sb_wr_bdata", byp_data0, 32'h77);
`else
    check("sb_wr_busy", 32'(sb_busy0), 32'd1);
`endif
    step();
    check("sb_clear", 32'(sb_busy0), 32'd0);
    check("sb_rf", rf_mem[7], 32'h77);

    // Same-edge set and clear of x7: set wins
    sb_set = 1'b1; sb_set_addr = 5'd7;
    step(); sb_set = 1'b0;
    req_valid = 2'b10; req_addr[9:5] = 5'd7; req_data[63:32] = 32'h7070;
    step(); req_valid = '0;
    sb_set = 1'b1; sb_set_addr = 5'd7;
    step(); sb_set = 1'b0;
    #1 check("sb_set_wins", 32'(sb_busy0), 32'd1);

    // Reset in the middle of a write to x5
    sb_set = 1'b1; sb_set_addr = 5'd5; q1 = 5'd5;
    step(); sb_set = 1'b0;
    req_valid = 2'b01; req_addr[4:0] = 5'd5; req_data[31:0] = 32'h1234;
    step(); req_valid = '0;
    #1 check("mid_ena_pre", 32'(rf_wr_ena), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_ena", 32'(rf_wr_ena), 32'd0);
    check("mid_busy5", 32'(sb_busy1), 32'd0);
    check("mid_busy7", 32'(sb_busy0), 32'd0);
    check("mid_gid", 32'(grant_id), 32'd0);
    @(negedge clk); #1 rst = 1'b1;
    step();
    check("mid_rf5", rf_mem[5], 32'd0);

    // Round-robin contention from pointer 0
    req_valid = 2'b11;
    req_addr[4:0] = 5'd1; req_data[31:0] = 32'hA1;
    req_addr[9:5] = 5'd2; req_data[63:32] = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_ready", 32'(req_ready), 32'(rr_ready[i]));
      step();
      check("rr_addr", 32'(rf_wr_addr), 32'(rr_addr[i]));
      check("rr_gid", 32'(grant_id), 32'(i % 2));
    end
    req_valid = '0;
    step();

    // Query x9 in the cycle its write is on the port
    sb_set = 1'b1; sb_set_addr = 5'd9; q1 = 5'd9;
    step(); sb_set = 1'b0;
    req_valid = 2'b01; req_addr[4:0] = 5'd9; req_data[31:0] = 32'h55;
    step(); req_valid = '0;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("byp_hit1", 32'(byp_hit1), 32'd1);
    check("byp_data1", byp_data1, 32'h55);
    check("byp_busy1", 32'(sb_busy1), 32'd0);
`else
    check("nobyp_busy1", 32'(sb_busy1), 32'd1);
`endif
    step();
    check("x9_clear", 32'(sb_busy1), 32'd0);
    check("x9_rf", rf_mem[9], 32'h55);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between N_REQ writeback sources (e.g. ALU, load unit, multi-cycle mul/div).
- Uses round-robin arbitration with a valid/ready handshake and drives a registered write port into the register file.
- Holds a 32-entry pending-write scoreboard so issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and the register file write channel.

Parameters:
- N_REQ, 2, number of writeback requesters (2..8).
- PTR_W, $clog2(N_REQ) (minimum 1), width of the round-robin pointer and grant_id. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-low
- req_valid  input  N_REQ  requester i has a write pending
- req_ready  output  N_REQ  requester i's write accepted this cycle
- req_addr  input  5*N_REQ  destination register of requester i, slice [5i+4:5i]
- req_data  input  32*N_REQ  write data of requester i, slice [32i+31:32i]
- rf_wr_ena  output  1  to register file wr_ena
- rf_wr_addr  output  5  to register file wr_addr
- rf_wr_data  output  32  to register file wr_data
- grant_id  output  PTR_W  index of the requester whose write is on rf_wr_*
- sb_set  input  1  issue logic marks sb_set_addr as pending
- sb_set_addr  input  5  destination register being issued
- sb_query_addr0, sb_query_addr1  input  5  source registers to check
- sb_busy0, sb_busy1  output  1  queried register has a pending write

Behaviour:
- Reset (rst=0, asynchronous): rf_wr_ena=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0, round-robin pointer=0, all 32 busy bits=0. An in-flight registered write is dropped.
- Arbitration (combinational):
  - Search req_valid starting at pointer ptr, wrapping modulo N_REQ. The first valid index k is granted.
  - req_ready is one-hot at k. req_ready=0 for all when no requester is valid.
  - At most one grant per cycle.
  - A requester must hold valid/addr/data stable until ready. Dropping valid before ready is allowed.
- Pointer update: after a grant to k, ptr <= (k+1) mod N_REQ. With no grant, ptr holds. Any continuously valid requester is granted within N_REQ cycles.
- Write stage (latency 1): on the edge where the handshake completes, rf_wr_addr<=req_addr[k], rf_wr_data<=req_data[k], grant_id<=k, rf_wr_ena<=1. With no grant, rf_wr_ena<=0 and addr/data/grant_id hold. The register file commits on the following edge.
- x0 writes: handshake completes normally (ready=1) but rf_wr_ena<=0 and the scoreboard is untouched.
- Scoreboard:
  - busy[a] is set on an edge with sb_set=1 and sb_set_addr=a, for a!=0.
  - busy[a] is cleared on the edge where rf_wr_ena=1 and rf_wr_addr=a, the same edge the register file captures data.
  - Simultaneous set and clear of the same address: set wins.
  - busy[0] is constant 0.
  - Writes to a register that is not busy are legal and leave it clear.
- Queries: sb_busyN = busy[sb_query_addrN], combinational. No internal forwarding unless the optional feature is enabled.
- Back-to-back writes to the same address from different requesters commit in grant order. The scoreboard clears on the first commit; ordering of multiple outstanding writes is the issuer's responsibility.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: adds outputs byp_hit0/byp_hit1 (1 bit each) and byp_data0/byp_data1 (32 bits each).
  - byp_hitN = rf_wr_ena && rf_wr_addr==sb_query_addrN && sb_query_addrN!=0.
  - byp_dataN = rf_wr_data.
  - sb_busyN is forced 0 when byp_hitN=1, so the consumer can issue one cycle earlier.
- Undefined: ports absent; sb_busyN is the raw busy bit.

Test Plan:
- Reset mid-write: sb_set x5, accept write x5=0x1234, assert rst=0 while rf_wr_ena=1 -> rf_wr_ena=0 immediately, busy[5]=0, pointer=0 after release.
- Single writer, N_REQ=2: req0 valid, addr=3, data=0xDEADBEEF -> req_ready=01 same cycle; next cycle rf_wr_ena=1, rf_wr_addr=3, grant_id=0; register file reads 0xDEADBEEF at x3 the cycle after.
- Round-robin contention: both valid for 4 cycles, addrs 1/2 -> grants 0,1,0,1; rf_wr_addr sequence 1,2,1,2; neither ready is ever starved.
- Scoreboard lifecycle: sb_set x7, query0=7 -> sb_busy0=1. Writeback x7 -> busy stays 1 through the rf_wr_ena cycle, then 0. Same-edge sb_set x7 with commit of x7 -> busy stays 1.
- x0 write: req1 valid, addr=0, data=0xFFFFFFFF -> req_ready=10, rf_wr_ena stays 0, query x0 -> sb_busy=0, x0 reads 0.
- With REGFILE_WB_BYPASS_EN: busy x9, write x9=0x55 on rf_wr_*, query1=9 -> byp_hit1=1, byp_data1=0x55, sb_busy1=0 in the rf_wr_ena cycle.
